// File: rtl/arb_pkg.sv
// Shared types and helpers for the priority/round-robin packet arbiter.
package arb_pkg;

  localparam int BEAT_CW = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Codes above 3 saturate at the longest packet (32 beats).
  function automatic logic [BEAT_CW-1:0] pkglen_beats(input int unsigned code);
    if (code > 3) return BEAT_CW'(32);
    return BEAT_CW'(4 << code);
  endfunction

  function automatic int unsigned id_none(input int unsigned n_ch);
    return n_ch;
  endfunction

endpackage

// File: rtl/prio_rr_pick.sv
// Combinational winner pick: lowest prio value, ties broken by distance after rr_ptr.
module prio_rr_pick #(
  parameter int N_CH = 4,
  parameter int PW   = 2,
  parameter int IW   = 3
) (
  input  logic [N_CH-1:0]    req_i,
  input  logic [N_CH*PW-1:0] prio_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic [IW-1:0]      win_id_o,
  output logic               found_o
);

  logic [PW-1:0] best_p;
  int            best_d;
  int            d;

  always_comb begin
    win_id_o = IW'(N_CH);
    found_o  = 1'b0;
    best_p   = '1;
    best_d   = N_CH;
    d        = 0;
    for (int k = 0; k < N_CH; k++) begin
      // d = 0 for the channel right after rr_ptr, growing with wrap
      d = (k + N_CH - int'(rr_ptr_i) - 1) % N_CH;
      if (req_i[k] && (!found_o || (prio_i[k*PW +: PW] < best_p) ||
                       ((prio_i[k*PW +: PW] == best_p) && (d < best_d)))) begin
        found_o  = 1'b1;
        best_p   = prio_i[k*PW +: PW];
        best_d   = d;
        win_id_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Packet arbiter: grants one channel per packet and locks it until the beat count completes.
module prio_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int DW   = 32,
  parameter  int PW   = 2,
  parameter  int LW   = 3,
  localparam int IW   = $clog2(N_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH*PW-1:0] slv_prio_i,
  input  logic [N_CH*LW-1:0] slv_pkglen_i,
  input  logic [N_CH*DW-1:0] slv_data_i,
  input  logic [N_CH-1:0]   slv_req_i,
  input  logic [N_CH-1:0]   slv_valid_i,
  input  logic              f2a_id_req_i,
  input  logic              f2a_ack_i,
  output logic [N_CH-1:0]   a2s_ack_o,
  output logic              a2f_valid_o,
  output logic [IW-1:0]     a2f_id_o,
  output logic [LW-1:0]     a2f_pkglen_sel_o,
  output logic [DW-1:0]     a2f_data_o,
  output logic              a2f_busy_o
);

  localparam logic [IW-1:0] ID_N = IW'(id_none(N_CH));

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        id_q, id_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]        pkglen_q, pkglen_d;
  logic [BEAT_CW-1:0]   target_q, target_d;
  logic [BEAT_CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]        win_id;
  logic                 win_found;
  logic [LW-1:0]        win_len;
  logic                 beat;

  prio_rr_pick #(.N_CH(N_CH), .PW(PW), .IW(IW)) u_pick (
    .req_i    (slv_req_i),
    .prio_i   (slv_prio_i),
    .rr_ptr_i (rr_ptr_q),
    .win_id_o (win_id),
    .found_o  (win_found)
  );

  always_comb begin
    win_len = '0;
    for (int k = 0; k < N_CH; k++)
      if (win_id == IW'(k)) win_len = slv_pkglen_i[k*LW +: LW];
  end

  // Output muxes key off the registered id; id N_CH selects the idle pattern.
  always_comb begin
    a2f_data_o  = '1;
    a2f_valid_o = 1'b0;
    a2s_ack_o   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (id_q == IW'(k)) begin
        a2f_data_o  = slv_data_i[k*DW +: DW];
        a2f_valid_o = slv_valid_i[k];
      end
      a2s_ack_o[k] = (state_q == ST_GRANT) && (id_q == IW'(k)) && f2a_ack_i;
    end
  end

  assign beat = (state_q == ST_GRANT) && f2a_ack_i && a2f_valid_o;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    pkglen_d = pkglen_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (f2a_id_req_i && win_found) begin
          state_d  = ST_GRANT;
          id_d     = win_id;
          rr_ptr_d = win_id;
          pkglen_d = win_len;
          target_d = pkglen_beats(32'(win_len));
          cnt_d    = '0;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          if (cnt_q + BEAT_CW'(1) == target_q) begin
            state_d = ST_IDLE;
            id_d    = ID_N;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BEAT_CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = ID_N;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      id_q     <= ID_N;
      rr_ptr_q <= IW'(N_CH - 1);
      pkglen_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      pkglen_q <= pkglen_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a2f_id_o         = id_q;
  assign a2f_pkglen_sel_o = pkglen_q;
  assign a2f_busy_o       = (state_q == ST_GRANT);

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter with hand-computed expectations.
module tb_prio_rr_arbiter;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int PW   = 2;
  localparam int LW   = 3;
  localparam int IW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*PW-1:0] prio;
  logic [N_CH*LW-1:0] pkglen;
  logic [N_CH*DW-1:0] data;
  logic [N_CH-1:0]   req, valid;
  logic              id_req, ack;
  logic [N_CH-1:0]   s_ack;
  logic              f_valid;
  logic [IW-1:0]     f_id;
  logic [LW-1:0]     f_len;
  logic [DW-1:0]     f_data;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  prio_rr_arbiter #(.N_CH(N_CH), .DW(DW), .PW(PW), .LW(LW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .slv_prio_i       (prio),
    .slv_pkglen_i     (pkglen),
    .slv_data_i       (data),
    .slv_req_i        (req),
    .slv_valid_i      (valid),
    .f2a_id_req_i     (id_req),
    .f2a_ack_i        (ack),
    .a2s_ack_o        (s_ack),
    .a2f_valid_o      (f_valid),
    .a2f_id_o         (f_id),
    .a2f_pkglen_sel_o (f_len),
    .a2f_data_o       (f_data),
    .a2f_busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n counted beats on channel ch; id must hold ch before each one
  task automatic run_beats(input int n, input int ch);
    for (int i = 0; i < n; i++) begin
      valid = '1;
      ack   = 1'b1;
      #1;
      chk("beat_id", f_id, ch);
      chk("beat_ack", s_ack, 4'(1 << ch));
      chk("beat_data", f_data, 32'hD000_0000 | ch);
      tick;
    end
    ack = 1'b0;
  endtask

  task automatic ack_no_valid(input int ch);
    valid     = '1;
    valid[ch] = 1'b0;
    ack       = 1'b1;
    #1;
    chk("nv_ack", s_ack, 4'(1 << ch));
    chk("nv_valid", f_valid, 0);
    tick;
    ack   = 1'b0;
    valid = '1;
    chk("nv_id_hold", f_id, ch);
  endtask

  initial begin
    rst = 1'b1; prio = '0; pkglen = '0; req = '0; valid = '0;
    id_req = 1'b0; ack = 1'b0;
    for (int k = 0; k < N_CH; k++) data[k*DW +: DW] = 32'hD000_0000 | k;
    tick; tick;
    chk("rst_id", f_id, 4);
    chk("rst_busy", busy, 0);
    chk("rst_len", f_len, 0);
    chk("rst_data", f_data, 32'hFFFF_FFFF);
    chk("rst_valid", f_valid, 0);
    rst = 1'b0;

    // no request: idle holds
    id_req = 1'b1;
    tick;
    chk("idle_noreq_id", f_id, 4);
    chk("idle_noreq_busy", busy, 0);

    // single request, code 0 -> 4 beats
    req = 4'b0001;
    tick;
    id_req = 1'b0;
    chk("g0_id", f_id, 0);
    chk("g0_busy", busy, 1);
    chk("g0_len", f_len, 0);
    run_beats(3, 0);
    chk("g0_hold", f_id, 0);
    run_beats(1, 0);
    chk("g0_rel_id", f_id, 4);
    chk("g0_rel_busy", busy, 0);
    chk("g0_rel_ack", s_ack, 0);

    // prio {3,1,1,2} for ch3..0; rr_ptr=0 -> ch1
    req = 4'b1111;
    prio = {2'd3, 2'd1, 2'd1, 2'd2};
    pkglen = {3'd0, 3'd2, 3'd0, 3'd0};
    id_req = 1'b1;
    tick;
    id_req = 1'b0;
    chk("rr1_id", f_id, 1);
    run_beats(4, 1);
    chk("rr1_rel", f_id, 4);
    // re-arbitrate on the first idle cycle -> ch2
    id_req = 1'b1;
    tick;
    id_req = 1'b0;
    chk("rr2_id", f_id, 2);
    chk("rr2_len", f_len, 2);

    // locked grant: inputs change, id_req pulses, 16 counted beats
    prio = '0; pkglen = {N_CH{3'd7}}; req = 4'b0001;
    id_req = 1'b1;
    run_beats(5, 2);
    id_req = 1'b0;
    ack_no_valid(2);
    run_beats(7, 2);
    ack_no_valid(2);
    ack_no_valid(2);
    run_beats(3, 2);
    chk("lock_id15", f_id, 2);
    chk("lock_len", f_len, 2);
    chk("lock_busy", busy, 1);
    run_beats(1, 2);
    chk("lock_rel", f_id, 4);
    chk("lock_rel_busy", busy, 0);

    // ch1 code 1 (8 beats), reset after beat 5
    req = 4'b0010; pkglen = {3'd0, 3'd0, 3'd1, 3'd0};
    id_req = 1'b1;
    tick;
    id_req = 1'b0;
    chk("g1_id", f_id, 1);
    chk("g1_len", f_len, 1);
    run_beats(5, 1);
    ack = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_id", f_id, 4);
    chk("mrst_ack", s_ack, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_len", f_len, 0);
    ack = 1'b0;

    // rr_ptr back to N_CH-1: equal-prio tie goes to ch0; code 7 -> 32 beats
    req = 4'b1111; prio = '0; pkglen = {3'd0, 3'd0, 3'd0, 3'd7};
    id_req = 1'b1;
    tick;
    id_req = 1'b0;
    chk("g7_id", f_id, 0);
    chk("g7_len", f_len, 7);
    run_beats(31, 0);
    chk("g7_hold", f_id, 0);
    run_beats(1, 0);
    chk("g7_rel", f_id, 4);
    chk("g7_rel_data", f_data, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
